// File: rtl/pc_seq_unit_if.sv
// Command/status bundle between the fetch control and the PC sequencer.
// Optional PC_HALT_EN adds the halt request and halted status signals.
interface pc_seq_unit_if #(
    parameter int D         = 12,
    parameter int OFF_W     = 9,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             branch_en;
    logic             jump_en;
    logic             call_en;
    logic             ret_en;
    logic [OFF_W-1:0] offset;
    logic [D-1:0]     target;
    logic [D-1:0]     prog_ctr;
    logic [CW-1:0]    ras_count;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_err;
`ifdef PC_HALT_EN
    logic             halt;
    logic             halted;

    modport master (
        output stall, branch_en, jump_en, call_en, ret_en, offset, target, halt,
        input  prog_ctr, ras_count, ras_full, ras_empty, ras_err, halted
    );
    modport slave (
        input  stall, branch_en, jump_en, call_en, ret_en, offset, target, halt,
        output prog_ctr, ras_count, ras_full, ras_empty, ras_err, halted
    );
`else
    modport master (
        output stall, branch_en, jump_en, call_en, ret_en, offset, target,
        input  prog_ctr, ras_count, ras_full, ras_empty, ras_err
    );
    modport slave (
        input  stall, branch_en, jump_en, call_en, ret_en, offset, target,
        output prog_ctr, ras_count, ras_full, ras_empty, ras_err
    );
`endif
endinterface

// File: rtl/pc_seq_unit.sv
// Fetch-stage PC sequencer: increment, relative branch, jump, call/ret via return-address stack.
// Optional PC_HALT_EN adds a sticky halt that freezes PC and stack until reset.
module pc_seq_unit #(
    parameter int D         = 12,
    parameter int OFF_W     = 9,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input logic          clk,
    input logic          reset,
    pc_seq_unit_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    localparam int IW = $clog2(RAS_DEPTH);
    localparam logic [D-1:0]  PC_ONE  = D'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    logic [D-1:0]  pc_q, pc_d, pc_inc, pc_rel;
    logic [CW-1:0] cnt_q, cnt_d, cnt_m1;
    logic          err_q, err_d;
    logic          full, empty, push, freeze;
    logic [IW-1:0] push_idx, pop_idx;
    logic [D-1:0]  ras_q [RAS_DEPTH];

    assign pc_inc   = pc_q + PC_ONE;
    // Size cast of a signed operand sign-extends, also correct when OFF_W == D.
    assign pc_rel   = pc_q + D'($signed(bus.offset));
    assign full     = (cnt_q == CNT_MAX);
    assign empty    = (cnt_q == '0);
    assign cnt_m1   = cnt_q - CNT_ONE;
    assign push_idx = cnt_q[IW-1:0];
    assign pop_idx  = cnt_m1[IW-1:0];

`ifdef PC_HALT_EN
    logic halted_q, halted_d;

    assign freeze     = bus.stall | halted_q | bus.halt;
    assign halted_d   = halted_q | (bus.halt & ~bus.stall);
    assign bus.halted = halted_q;

    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end
`else
    assign freeze = bus.stall;
`endif

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (freeze) begin
            pc_d = pc_q;
        end else if (bus.ret_en) begin
            if (empty) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end else begin
                pc_d  = ras_q[pop_idx];
                cnt_d = cnt_m1;
            end
        end else if (bus.call_en) begin
            if (full) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end else begin
                pc_d  = bus.target;
                cnt_d = cnt_q + CNT_ONE;
                push  = 1'b1;
            end
        end else if (bus.jump_en) begin
            pc_d = bus.target;
        end else if (bus.branch_en) begin
            pc_d = pc_rel;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= D'(RESET_VEC);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack contents need no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) ras_q[push_idx] <= pc_inc;
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.ras_count = cnt_q;
    assign bus.ras_full  = full;
    assign bus.ras_empty = empty;
    assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit with D=12, OFF_W=9, RAS_DEPTH=4, RESET_VEC=0.
module tb_pc_seq_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pc_seq_unit_if #(.D(12), .OFF_W(9), .RAS_DEPTH(4)) bus ();

    pc_seq_unit #(.D(12), .OFF_W(9), .RAS_DEPTH(4), .RESET_VEC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of commands, clock it, then return all commands to idle.
    task automatic cyc(input logic st, input logic rt, input logic cl, input logic jp,
                       input logic br, input logic [8:0] off, input logic [11:0] tgt);
        bus.stall = st; bus.ret_en = rt; bus.call_en = cl; bus.jump_en = jp;
        bus.branch_en = br; bus.offset = off; bus.target = tgt;
        @(posedge clk); #1;
        bus.stall = 0; bus.ret_en = 0; bus.call_en = 0; bus.jump_en = 0;
        bus.branch_en = 0; bus.offset = '0; bus.target = '0;
    endtask

    task automatic idle();                  cyc(0, 0, 0, 0, 0, 9'h0, 12'h0); endtask
    task automatic jump(input logic [11:0] t); cyc(0, 0, 0, 1, 0, 9'h0, t);  endtask
    task automatic call(input logic [11:0] t); cyc(0, 0, 1, 0, 0, 9'h0, t);  endtask
    task automatic ret();                   cyc(0, 1, 0, 0, 0, 9'h0, 12'h0); endtask
    task automatic branch(input logic [8:0] o); cyc(0, 0, 0, 0, 1, o, 12'h0); endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.stall = 0; bus.ret_en = 0; bus.call_en = 0; bus.jump_en = 0;
        bus.branch_en = 0; bus.offset = '0; bus.target = '0;
`ifdef PC_HALT_EN
        bus.halt = 0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pc", bus.prog_ctr, 32'h0);
        check("rst_cnt", bus.ras_count, 32'd0);
        check("rst_empty", bus.ras_empty, 32'd1);
        check("rst_full", bus.ras_full, 32'd0);
        check("rst_err", bus.ras_err, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("inc_pc", bus.prog_ctr, 32'(i));
        end

        jump(12'h010);  check("jump_pc", bus.prog_ctr, 32'h010);
        branch(9'h1FD); check("br_neg", bus.prog_ctr, 32'h00D);
        jump(12'hFFE);
        branch(9'h004); check("br_wrap", bus.prog_ctr, 32'h002);
        branch(9'h000); check("br_self", bus.prog_ctr, 32'h002);
        branch(9'h100); check("br_min_wrap", bus.prog_ctr, 32'hF02);
        jump(12'hFFF);
        idle();         check("inc_wrap", bus.prog_ctr, 32'h000);

        jump(12'h020);
        call(12'h300);  check("call_pc", bus.prog_ctr, 32'h300);
        check("call_cnt", bus.ras_count, 32'd1);
        ret();          check("ret_pc", bus.prog_ctr, 32'h021);
        check("ret_empty", bus.ras_empty, 32'd1);

        jump(12'h010);
        call(12'h100); call(12'h200); call(12'h300); call(12'h400);
        check("fill_pc", bus.prog_ctr, 32'h400);
        check("fill_full", bus.ras_full, 32'd1);
        check("fill_err", bus.ras_err, 32'd0);
        call(12'h500);  check("ovf_pc", bus.prog_ctr, 32'h401);
        check("ovf_err", bus.ras_err, 32'd1);
        check("ovf_cnt", bus.ras_count, 32'd4);
        ret(); check("pop1", bus.prog_ctr, 32'h301);
        ret(); check("pop2", bus.prog_ctr, 32'h201);
        ret(); check("pop3", bus.prog_ctr, 32'h101);
        ret(); check("pop4", bus.prog_ctr, 32'h011);
        check("pop_empty", bus.ras_empty, 32'd1);

        do_reset();
        check("rst2_err", bus.ras_err, 32'd0);
        jump(12'h050);
        ret();          check("unf_pc", bus.prog_ctr, 32'h051);
        check("unf_err", bus.ras_err, 32'd1);
        check("unf_cnt", bus.ras_count, 32'd0);
        call(12'h123);  check("sticky_call_pc", bus.prog_ctr, 32'h123);
        check("sticky_err1", bus.ras_err, 32'd1);
        ret();          check("sticky_ret_pc", bus.prog_ctr, 32'h052);
        check("sticky_err2", bus.ras_err, 32'd1);

        do_reset();
        jump(12'h040);
        cyc(1, 0, 1, 0, 0, 9'h0, 12'h300);
        check("stall_pc", bus.prog_ctr, 32'h040);
        check("stall_cnt", bus.ras_count, 32'd0);
        cyc(1, 1, 0, 0, 0, 9'h0, 12'h0);
        check("stall_ret_err", bus.ras_err, 32'd0);
        call(12'h300);  check("call2_cnt", bus.ras_count, 32'd1);
        cyc(0, 1, 1, 1, 0, 9'h0, 12'h777);
        check("prio_ret_pc", bus.prog_ctr, 32'h041);
        check("prio_ret_cnt", bus.ras_count, 32'd0);
        cyc(0, 0, 1, 1, 1, 9'h005, 12'h222);
        check("prio_call_pc", bus.prog_ctr, 32'h222);
        check("prio_call_cnt", bus.ras_count, 32'd1);
        cyc(0, 0, 0, 1, 1, 9'h005, 12'h333);
        check("prio_jump_pc", bus.prog_ctr, 32'h333);
        bus.stall = 1; bus.call_en = 1; bus.target = 12'h555;
        do_reset();
        bus.stall = 0; bus.call_en = 0; bus.target = '0;
        check("rst_stall_pc", bus.prog_ctr, 32'h0);
        check("rst_stall_cnt", bus.ras_count, 32'd0);

`ifdef PC_HALT_EN
        check("halted_init", bus.halted, 32'd0);
        jump(12'h060);
        bus.halt = 1;
        call(12'h700);
        bus.halt = 0;
        check("halt_pc", bus.prog_ctr, 32'h060);
        check("halt_flag", bus.halted, 32'd1);
        jump(12'h123);  check("halt_frozen", bus.prog_ctr, 32'h060);
        check("halt_cnt", bus.ras_count, 32'd0);
        do_reset();
        check("halt_rst", bus.halted, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
